// File: rtl/shift_right_seq_pkg.sv
// shift_right_seq_pkg: shared widths, FSM states and ALU shift funct codes
package shift_right_seq_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SHW = 5;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_e;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  // Lets the decoder derive arith from the same codes this block is built around
  function automatic logic is_arith(input logic [5:0] fn);
    return fn == FN_SRA || fn == FN_SRAV;
  endfunction
endpackage

// File: rtl/shift_right_seq_if.sv
// shift_right_seq_if: start/busy/done request bus between ALU control and the right shifter
interface shift_right_seq_if
  import shift_right_seq_pkg::*;
#(parameter int WIDTH = DEF_WIDTH, parameter int SHW = DEF_SHW);
  logic start;
  logic arith;
  logic [WIDTH-1:0] tg;
  logic [SHW-1:0] sh;
  logic busy;
  logic done;
  logic [WIDTH-1:0] res;
  modport master (output start, arith, tg, sh, input busy, done, res);
  modport slave (input start, arith, tg, sh, output busy, done, res);
endinterface

// File: rtl/shift_right_step.sv
// shift_right_step: one-bit right shift with logical or sign fill
module shift_right_step #(parameter int WIDTH = 32) (
  input logic [WIDTH-1:0] in,
  input logic fill_sign,
  output logic [WIDTH-1:0] out
);
  assign out = {fill_sign & in[WIDTH-1], in[WIDTH-1:1]};
endmodule

// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-cycle SRL/SRA shifter, one bit per clock under start/busy/done
module shift_right_seq
  import shift_right_seq_pkg::*;
#(parameter int WIDTH = DEF_WIDTH, parameter int SHW = DEF_SHW) (
  input logic clk,
  input logic rst,
  shift_right_seq_if.slave bus
);
  state_e st, st_n;
  logic [WIDTH-1:0] work, work_sh, res_q;
  logic [SHW-1:0] cnt;
  logic fill_sign, accept, last;
  shift_right_step #(.WIDTH(WIDTH)) u_step (.in(work), .fill_sign(fill_sign), .out(work_sh));
  // DONE accepts like IDLE so back-to-back ops need no bubble
  assign accept = bus.start && (st == ST_IDLE || st == ST_DONE);
  assign last = cnt == SHW'(1);
  // Unused encoding 2'd3 falls through to IDLE since accept is low there
  always_comb begin
    st_n = ST_IDLE;
    st_n = (st == ST_SHIFT) ? (last ? ST_DONE : ST_SHIFT)
         : accept ? ((bus.sh != '0) ? ST_SHIFT : ST_DONE) : ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= ST_IDLE;
      work <= '0;
      cnt <= '0;
      fill_sign <= 1'b0;
      res_q <= '0;
    end else begin
      st <= st_n;
      if (accept) begin
        work <= bus.tg;
        cnt <= bus.sh;
        fill_sign <= bus.arith;
        if (bus.sh == '0) res_q <= bus.tg;
      end else if (st == ST_SHIFT) begin
        work <= work_sh;
        cnt <= cnt - SHW'(1);
        if (last) res_q <= work_sh;
      end
    end
  end
  assign bus.busy = st == ST_SHIFT;
  assign bus.done = st == ST_DONE;
  assign bus.res = res_q;
endmodule

// File: tb/tb_shift_right_seq.sv
// tb_shift_right_seq: directed cases plus random sweep against a tg>>sh / >>> reference
module tb_shift_right_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  shift_right_seq_if b ();
  shift_right_seq dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [31:0] t, input int s, input logic a);
    logic signed [31:0] st;
    st = $signed(t);
    if (a) begin
      st = st >>> s;
      return st;
    end
    return t >> s;
  endfunction
  // Issues an op at the current negedge; returns at the negedge of the done cycle with start low
  task automatic do_op(input logic [31:0] t, input logic [4:0] s, input logic a, input bit poke);
    int n;
    logic [31:0] prev;
    prev = b.res;
    b.start = 1'b1;
    b.tg = t;
    b.sh = s;
    b.arith = a;
    @(negedge clk);
    b.start = 1'b0;
    b.tg = $urandom;
    b.sh = 5'($urandom_range(0, 31));
    b.arith = 1'($urandom_range(0, 1));
    n = 0;
    while (!b.done && n < 40) begin
      check("busy_while_shifting", 32'(b.busy), 32'd1);
      check("res_stable", b.res, prev);
      n++;
      b.start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    b.start = 1'b0;
    check("done_seen", 32'(b.done), 32'd1);
    check("busy_excl", 32'(b.busy), 32'd0);
    check("busy_cycles", 32'(n), 32'(s));
    check("res", b.res, model(t, int'(s), a));
  endtask
  initial begin
    logic [31:0] hold;
    b.start = 1'b0;
    b.tg = '0;
    b.sh = '0;
    b.arith = 1'b0;
    #1;
    check("rst_res", b.res, 32'd0);
    check("rst_busy", 32'(b.busy), 32'd0);
    check("rst_done", 32'(b.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(32'h80000000, 5'd4, 1'b0, 1'b0);
    check("c1_res", b.res, 32'h08000000);
    @(negedge clk);
    check("done_pulse", 32'(b.done), 32'd0);
    do_op(32'h80000000, 5'd4, 1'b1, 1'b0);
    check("c2_res", b.res, 32'hF8000000);
    @(negedge clk);
    do_op(32'hAAAAAAAA, 5'd0, 1'b0, 1'b0);
    check("c3_res", b.res, 32'hAAAAAAAA);
    @(negedge clk);
    do_op(32'hFFFFFFFF, 5'd31, 1'b0, 1'b0);
    check("c4a_res", b.res, 32'h00000001);
    @(negedge clk);
    do_op(32'hFFFFFFFF, 5'd31, 1'b1, 1'b0);
    check("c4b_res", b.res, 32'hFFFFFFFF);
    do_op(32'h0000FF00, 5'd8, 1'b0, 1'b1);
    check("c5_res", b.res, 32'h000000FF);
    @(negedge clk);
    b.start = 1'b1;
    b.tg = 32'h12345678;
    b.sh = 5'd10;
    b.arith = 1'b0;
    @(negedge clk);
    b.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    hold = b.res;
    check("c6_pre_busy", 32'(b.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("c6_busy", 32'(b.busy), 32'd0);
    check("c6_done", 32'(b.done), 32'd0);
    check("c6_res", b.res, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      check("c6_no_done", 32'(b.done), 32'd0);
    end
    do_op(32'h00000010, 5'd4, 1'b0, 1'b0);
    check("c6_fresh", b.res, 32'h00000001);
    for (int i = 0; i < 1000; i++) begin
      hold = b.res;
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        @(negedge clk);
        check("idle_res_stable", b.res, hold);
        check("idle_quiet", 32'({b.busy, b.done}), 32'd0);
      end
      do_op($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
